// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO, 16x oversampled framing with configurable data/stop/parity.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | line idle (or break), waiting for enable + data
// START   | start bit, TxD = 0
// DATA    | data bits LSB first, 7 or 8 bits
// PARITY  | parity bit, odd or even
// STOP    | stop bit(s), TxD = 1, one or two bit times
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int OS_RATE    = 16
) (
    input  logic       CLK50MHZ,
    input  logic       rst,
    input  logic       Baud_tick,
    input  logic       tx_enable,
    input  logic       D_num,
    input  logic       S_num,
    input  logic [1:0] Par,
    input  logic [7:0] in_data,
    input  logic       n_WR,
    input  logic       Clr_EF,
`ifdef UART_TX_BREAK_EN
    input  logic       Send_Brk,
`endif
    output logic       TxD,
    output logic       Tx_RDY,
    output logic       Tx_EMPTY,
    output logic       OV_Fg,
    output logic       n_INT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] TICK_LAST = 4'(OS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          baud_q, tick_q;
    logic          nwr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          d8_q, d8_d;
    logic          s2_q, s2_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          txd_q, txd_d;
    logic          rdy_q, rdy_d;
    logic          empty_q, empty_d;
    logic          ov_q, ov_d;

    logic          wr_fire, push, pop, ov_set;
    logic          fifo_full, fifo_empty;
    logic          bit_end;
    logic [2:0]    last_data, last_stop;
    logic [7:0]    head_data;
    logic          brk_block, idle_txd;

    assign wr_fire    = ~n_WR & nwr_q;
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign bit_end    = tick_q && (tick_cnt_q == TICK_LAST);
    assign last_data  = d8_q ? 3'd7 : 3'd6;
    assign last_stop  = s2_q ? 3'd1 : 3'd0;
    assign head_data  = D_num ? mem_q[rd_ptr_q] : {1'b0, mem_q[rd_ptr_q][6:0]};

`ifdef UART_TX_BREAK_EN
    logic       brk_pend_q, brk_pend_d;
    logic [3:0] brk_cnt_q, brk_cnt_d;

    assign brk_block = Send_Brk | brk_pend_q;
    assign idle_txd  = ~Send_Brk;

    // After a break the line must show a full bit time of mark before the next start.
    always_comb begin
        brk_pend_d = brk_pend_q;
        brk_cnt_d  = brk_cnt_q;
        if (Send_Brk) begin
            brk_cnt_d = '0;
            if (state_q == S_IDLE) begin
                brk_pend_d = 1'b1;
            end
        end else if (brk_pend_q && tick_q) begin
            if (brk_cnt_q == TICK_LAST) begin
                brk_pend_d = 1'b0;
                brk_cnt_d  = '0;
            end else begin
                brk_cnt_d = brk_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK50MHZ or negedge rst) begin
        if (!rst) begin
            brk_pend_q <= 1'b0;
            brk_cnt_q  <= '0;
        end else begin
            brk_pend_q <= brk_pend_d;
            brk_cnt_q  <= brk_cnt_d;
        end
    end
`else
    assign brk_block = 1'b0;
    assign idle_txd  = 1'b1;
`endif

    // State register and all other flops.
    always_ff @(posedge CLK50MHZ or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            baud_q     <= 1'b0;
            tick_q     <= 1'b0;
            nwr_q      <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            d8_q       <= 1'b0;
            s2_q       <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            txd_q      <= 1'b1;
            rdy_q      <= 1'b1;
            empty_q    <= 1'b1;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= Baud_tick;
            tick_q     <= Baud_tick & ~baud_q;
            nwr_q      <= n_WR;
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            d8_q       <= d8_d;
            s2_q       <= s2_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            txd_q      <= txd_d;
            rdy_q      <= rdy_d;
            empty_q    <= empty_d;
            ov_q       <= ov_d;
        end
    end

    // Next-state and frame datapath.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        d8_d       = d8_q;
        s2_d       = s2_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        pop        = 1'b0;

        if (state_q != S_IDLE && tick_q) begin
            tick_cnt_d = bit_end ? 4'd0 : tick_cnt_q + 4'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (tx_enable && !fifo_empty && !brk_block) begin
                    state_d   = S_START;
                    pop       = 1'b1;
                    shift_d   = head_data;
                    d8_d      = D_num;
                    s2_d      = S_num;
                    par_en_d  = ^Par;
                    par_bit_d = (^head_data) ^ (Par == 2'b01);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == last_data) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == last_stop) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A write colliding with a pop on a full FIFO still fits.
    always_comb begin
        push     = wr_fire && (!fifo_full || pop);
        ov_set   = wr_fire && fifo_full && !pop;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        if (ov_set) begin
            ov_d = 1'b1;
        end else if (Clr_EF) begin
            ov_d = 1'b0;
        end else begin
            ov_d = ov_q;
        end
    end

    // Outputs, registered from the next state so TxD tracks state transitions.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            S_IDLE:   txd_d = idle_txd;
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_bit_d;
            S_STOP:   txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
        rdy_d   = (cnt_d != CW'(FIFO_DEPTH));
        empty_d = (cnt_d == '0) && (state_d == S_IDLE);
    end

    assign TxD      = txd_q;
    assign Tx_RDY   = rdy_q;
    assign Tx_EMPTY = empty_q;
    assign OV_Fg    = ov_q;
    assign n_INT    = ~(ov_q | empty_q);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a tick-sampling
// monitor decodes TxD and compares each frame bit by bit.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int OS = 16;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       Baud_tick = 1'b0;
    logic       tx_enable = 1'b0;
    logic       D_num     = 1'b1;
    logic       S_num     = 1'b0;
    logic [1:0] Par       = 2'b00;
    logic [7:0] in_data   = 8'h00;
    logic       n_WR      = 1'b1;
    logic       Clr_EF    = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic       Send_Brk  = 1'b0;
`endif
    logic       TxD, Tx_RDY, Tx_EMPTY, OV_Fg, n_INT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] bits;
        int          len;
        int          gap;
    } frame_t;

    frame_t sb_q[$];
    bit     mon_en   = 1'b1;
    bit     in_frame = 1'b0;
    int     tcnt     = 0;

    uart_tx #(.FIFO_DEPTH(4), .OS_RATE(16)) dut (
        .CLK50MHZ (clk),
        .rst      (rst),
        .Baud_tick(Baud_tick),
        .tx_enable(tx_enable),
        .D_num    (D_num),
        .S_num    (S_num),
        .Par      (Par),
        .in_data  (in_data),
        .n_WR     (n_WR),
        .Clr_EF   (Clr_EF),
`ifdef UART_TX_BREAK_EN
        .Send_Brk (Send_Brk),
`endif
        .TxD      (TxD),
        .Tx_RDY   (Tx_RDY),
        .Tx_EMPTY (Tx_EMPTY),
        .OV_Fg    (OV_Fg),
        .n_INT    (n_INT)
    );

    always #5 clk = ~clk;

    // One Baud_tick pulse (one clock wide) every four clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            Baud_tick = (tcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [11:0] bits, input int len, input int gap);
        frame_t f;
        f.bits = bits;
        f.len  = len;
        f.gap  = gap;
        sb_q.push_back(f);
    endtask

    // Sample TxD once per tick, in the cycle after the pulse, where the line is stable.
    initial begin : monitor
        frame_t      cur;
        int          samp;
        int          idle_run;
        bit          ok;
        bit          spurious;
        logic [11:0] got;
        samp     = 0;
        idle_run = 0;
        ok       = 1'b1;
        spurious = 1'b0;
        got      = '0;
        cur.bits = '1;
        cur.len  = 10;
        cur.gap  = -1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
                idle_run = 0;
            end else if (tcnt == 1) begin
                if (!in_frame) begin
                    if (TxD === 1'b0 && mon_en) begin
                        in_frame = 1'b1;
                        samp     = 0;
                        ok       = 1'b1;
                        got      = '0;
                        spurious = 1'b0;
                        if (sb_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_frame: start bit seen with no frame queued");
                            spurious = 1'b1;
                            cur.bits = '1;
                            cur.len  = 10;
                            cur.gap  = -1;
                        end else begin
                            cur = sb_q.pop_front();
                            if (cur.gap >= 0) begin
                                checks++;
                                if (idle_run != cur.gap) begin
                                    failures++;
                                    $display("FAIL frame_gap: idle ticks %0d expected %0d", idle_run, cur.gap);
                                end
                            end
                        end
                    end else begin
                        idle_run++;
                    end
                end
                if (in_frame) begin
                    if (samp % OS == OS / 2) got[samp / OS] = TxD;
                    if (TxD !== cur.bits[samp / OS]) ok = 1'b0;
                    samp++;
                    if (samp == cur.len * OS) begin
                        in_frame = 1'b0;
                        idle_run = 0;
                        if (!spurious) begin
                            checks++;
                            if (!ok) begin
                                failures++;
                                $display("FAIL frame: got bits %h expected %h (len %0d)", got, cur.bits, cur.len);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, output logic txd2);
        @(posedge clk);
        #1;
        in_data = d;
        n_WR    = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        txd2 = TxD;
        n_WR = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || in_frame) && n < 8000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done"}, (sb_q.size() == 0 && !in_frame), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic t2;
        int   lows;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd",   TxD,      1);
        check("rst_rdy",   Tx_RDY,   1);
        check("rst_empty", Tx_EMPTY, 1);
        check("rst_ov",    OV_Fg,    0);
        check("rst_nint",  n_INT,    0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1, 0x35
        D_num = 1'b1; S_num = 1'b0; Par = 2'b00; tx_enable = 1'b1;
        push_frame(12'h26A, 10, -1);
        write_byte(8'h35, t2);
        check("latency_txd_low", t2, 0);
        wait_done("f8n1");
        check("empty_8n1", Tx_EMPTY, 1);
        check("nint_8n1",  n_INT,    0);

        // 8E2, 0xA5
        Par = 2'b10; S_num = 1'b1;
        push_frame(12'hD4A, 12, -1);
        write_byte(8'hA5, t2);
        wait_done("f8e2");
        check("empty_8e2", Tx_EMPTY, 1);

        // 7O1, 0xC1 (bit 7 not sent)
        D_num = 1'b0; S_num = 1'b0; Par = 2'b01;
        push_frame(12'h382, 10, -1);
        write_byte(8'hC1, t2);
        wait_done("f7o1");
        check("empty_7o1", Tx_EMPTY, 1);

        // Overflow, clear, then a write colliding with the first pop while full
        D_num = 1'b1; S_num = 1'b0; Par = 2'b00; tx_enable = 1'b0;
        push_frame(12'h202, 10, -1);
        push_frame(12'h204, 10, 0);
        push_frame(12'h206, 10, 0);
        push_frame(12'h208, 10, 0);
        write_byte(8'h01, t2);
        write_byte(8'h02, t2);
        write_byte(8'h03, t2);
        check("rdy_after_3", Tx_RDY, 1);
        write_byte(8'h04, t2);
        check("rdy_after_4",  Tx_RDY, 0);
        check("nint_full",    n_INT,  1);
        check("ov_before_5",  OV_Fg,  0);
        write_byte(8'h05, t2);
        check("ov_after_5",   OV_Fg,  1);
        check("nint_ov",      n_INT,  0);
        check("rdy_after_5",  Tx_RDY, 0);
        @(posedge clk);
        #1;
        Clr_EF = 1'b1;
        @(posedge clk);
        #1;
        Clr_EF = 1'b0;
        @(posedge clk);
        #1;
        check("ov_cleared",   OV_Fg, 0);
        check("nint_cleared", n_INT, 1);

        push_frame(12'h20C, 10, 0);
        @(posedge clk);
        #1;
        tx_enable = 1'b1;
        in_data   = 8'h06;
        n_WR      = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        n_WR = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ov_write_pop_full",  OV_Fg,  0);
        check("rdy_write_pop_full", Tx_RDY, 0);
        wait_done("burst");
        check("empty_burst", Tx_EMPTY, 1);
        check("ov_burst",    OV_Fg,    0);

        // Mid-frame reset discards the frame and the queued byte
        mon_en = 1'b0;
        write_byte(8'h00, t2);
        write_byte(8'h00, t2);
        repeat (120) @(posedge clk);
        #1;
        check("txd_low_in_data", TxD, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("txd_async_reset",  TxD,      1);
        check("empty_in_reset",   Tx_EMPTY, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        check("no_frame_after_reset", lows, 0);
        check("empty_after_reset",    Tx_EMPTY, 1);
        check("rdy_after_reset",      Tx_RDY,   1);
        mon_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
